// File: rtl/apb_io_fabric.sv
`default_nettype none
// ============================================================================
// Module   : apb_io_fabric
// Brief    : APB interconnect from one master to NUM_SLAVES peripherals with
//            registered downstream re-launch, timeout and sticky error log.
// Revision : 1.0
// ============================================================================
module apb_io_fabric #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int SEL_LSB        = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [ADDR_W-1:0]            m_paddr,
    input  logic [DATA_W-1:0]            m_pwdata,
    input  logic                         m_pwrite,
    input  logic                         m_psel,
    input  logic                         m_penable,
    output logic [DATA_W-1:0]            m_prdata,
    output logic                         m_pready,
    output logic                         m_pslverr,
    output logic [ADDR_W-1:0]            s_paddr,
    output logic [DATA_W-1:0]            s_pwdata,
    output logic                         s_pwrite,
    output logic                         s_penable,
    output logic [NUM_SLAVES-1:0]        s_psel,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_prdata,
    input  logic [NUM_SLAVES-1:0]        s_pready,
    input  logic                         err_clr,
    output logic [7:0]                   err_count,
    output logic [ADDR_W-1:0]            err_addr,
    output logic                         err_timeout
);

    localparam int IDX_W  = $clog2(NUM_SLAVES);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam int HI_LSB = SEL_LSB + IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W:0]   SLAVE_LIMIT = (IDX_W+1)'(NUM_SLAVES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic [IDX_W-1:0]    dec_idx;
    logic                upper_zero;
    logic                mapped;
    logic                setup_seen;
    logic                timeout_hit;
    logic                err_event;
    logic [NUM_SLAVES-1:0] sel_onehot;
    logic [DATA_W-1:0]   slv_rdata [NUM_SLAVES];

    assign dec_idx = m_paddr[SEL_LSB +: IDX_W];

    generate
        if (HI_LSB < ADDR_W) begin : g_upper_check
            assign upper_zero = (m_paddr[ADDR_W-1:HI_LSB] == '0);
        end else begin : g_no_upper_check
            assign upper_zero = 1'b1;
        end
    endgenerate

    generate
        for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_unpack
            assign slv_rdata[g] = s_prdata[g*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dec_idx == IDX_W'(i)) begin
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign mapped      = upper_zero && ({1'b0, dec_idx} < SLAVE_LIMIT);
    assign setup_seen  = (state == IDLE) && m_psel && !m_penable;
    assign timeout_hit = (state == ACCESS) && !s_pready[idx_q] && (count == CNT_MAX);
    assign err_event   = (setup_seen && !mapped) || timeout_hit;

    // A response is presented only while the master still selects us.
    assign m_pready  = (state == RESP) && m_psel;
    assign m_pslverr = m_pready && err_q;
    assign m_prdata  = m_pready ? rdata_q : '0;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            idx_q       <= '0;
            count       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            s_paddr     <= '0;
            s_pwdata    <= '0;
            s_pwrite    <= 1'b0;
            s_penable   <= 1'b0;
            s_psel      <= '0;
            err_count   <= '0;
            err_addr    <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup_seen) begin
                        s_paddr  <= m_paddr;
                        s_pwdata <= m_pwdata;
                        s_pwrite <= m_pwrite;
                        idx_q    <= dec_idx;
                        if (mapped) begin
                            err_q  <= 1'b0;
                            s_psel <= sel_onehot;
                            state  <= SETUP;
                        end else begin
                            err_q   <= 1'b1;
                            rdata_q <= '1;
                            state   <= RESP;
                        end
                    end
                end
                SETUP: begin
                    count     <= '0;
                    s_penable <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (s_pready[idx_q]) begin
                        rdata_q   <= s_pwrite ? '0 : slv_rdata[idx_q];
                        err_q     <= 1'b0;
                        s_psel    <= '0;
                        s_penable <= 1'b0;
                        state     <= RESP;
                    end else if (count == CNT_MAX) begin
                        rdata_q   <= '1;
                        err_q     <= 1'b1;
                        s_psel    <= '0;
                        s_penable <= 1'b0;
                        state     <= RESP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A clear coinciding with a new error still records that error.
            if (err_event) begin
                err_addr    <= (state == IDLE) ? m_paddr : s_paddr;
                err_timeout <= (state == ACCESS);
                if (err_clr) begin
                    err_count <= 8'd1;
                end else if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (err_clr) begin
                err_count <= '0;
            end
        end
    end

endmodule
`default_nettype wire
